// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: accepts one word access,
// holds the pipeline with Stall for LATENCY cycles, then pulses Done with read data.
module dmem_responder #(
  parameter int unsigned MEM_WORDS = 256,
  parameter int unsigned LATENCY   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        Busy,
  output logic        err
);

  localparam int unsigned IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                wr_q;
  logic [DATA_W-1:0]   mem [MEM_WORDS];

  logic                req;
  logic                illegal;
  logic                legal;
  logic                take;
  logic [IDX_W-1:0]    addr_idx;
  logic [IDX_W-1:0]    op_idx;
  logic [DATA_W-1:0]   op_data;
  logic                op_wr;
  logic                finish;

  // Request decode; out-of-range check uses the full word index, not the truncated one
  assign req      = Rd | Wr;
  assign illegal  = req & ((Rd & Wr) | Addr[0] | (32'(Addr[15:1]) >= 32'(MEM_WORDS)));
  assign legal    = req & ~illegal;
  assign take     = (state == IDLE) & legal;
  assign addr_idx = Addr[IDX_W:1];
  assign finish   = (next_state == DONE);

  // With LATENCY=1 the access completes on its acceptance edge, so use live inputs
  assign op_wr   = take ? Wr       : wr_q;
  assign op_idx  = take ? addr_idx : idx_q;
  assign op_data = take ? DataIn   : wdata_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (legal) next_state = (LATENCY <= 1) ? DONE : BUSY;
      BUSY:    if (cnt <= CNT_W'(1)) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Combinational outputs, forced low while reset is asserted
  always_comb begin
    Stall = 1'b0;
    err   = 1'b0;
    if (rst) begin
      case (state)
        IDLE: begin
          Stall = legal;
          err   = illegal;
        end
        BUSY:    Stall = 1'b1;
        default: ;
      endcase
    end
  end

  // Latched request and latency counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else if (take) begin
      cnt     <= CNT_W'(LATENCY - 1);
      idx_q   <= addr_idx;
      wdata_q <= DataIn;
      wr_q    <= Wr;
    end else if (state == BUSY && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Registered status and read data; DataOut only changes on a completing read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Done    <= 1'b0;
      Busy    <= 1'b0;
      DataOut <= '0;
    end else begin
      Done <= finish;
      Busy <= (next_state == BUSY);
      if (finish && !op_wr) DataOut <= mem[op_idx];
    end
  end

  // Storage; a write commits on the edge entering DONE, so a reset in BUSY drops it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
    end else if (finish && op_wr) begin
      mem[op_idx] <= op_data;
    end
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder that serves the MEM stage's read/write requests: the other end of the memRead/memWrite/address/writeData interface.
- Accepts one word access at a time, holds the pipeline with Stall for a fixed latency, then pulses Done with read data.
- Replaces the single-cycle data memory so the processor is exercised against realistic stall timing.

Parameters:
- MEM_WORDS, 256, number of 16-bit words stored; legal byte addresses are 0 to 2*MEM_WORDS-2, even only.
- LATENCY, 4, cycles from acceptance edge to Done; legal range 1 to 15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- Addr  input  16  byte address from EX/MEM ALU result.
- DataIn  input  16  store data.
- Rd  input  1  read request, level.
- Wr  input  1  write request, level.
- DataOut  output  16  read data, valid while Done=1, held afterwards.
- Done  output  1  one-cycle completion pulse.
- Stall  output  1  pipeline hold, combinational.
- Busy  output  1  registered; 1 while an access is in flight.
- err  output  1  combinational; flags an illegal request in the current cycle.

Behaviour:
- Reset (rst=0, async): state IDLE, counter 0, DataOut=0, Done=0, Busy=0, all storage words cleared to 0. Stall and err evaluate to 0 while in reset.
- State machine has three states: IDLE, BUSY, DONE.
- Request definition:
  - req = Rd|Wr.
  - illegal = req & (Rd&Wr | Addr[0] | Addr[15:1] >= MEM_WORDS).
  - legal = req & ~illegal.
- IDLE:
  - A legal request on a rising edge latches the address index, DataIn and operation, loads the counter with LATENCY-1, and moves to BUSY.
  - If LATENCY=1 it moves straight to DONE.
  - Stall = legal (combinational) in the request cycle.
- BUSY:
  - Stall=1, Busy=1.
  - Counter decrements each cycle; when it reaches 1 the next edge moves to DONE.
  - Rd/Wr/Addr/DataIn are ignored; the latched copies are used.
- DONE:
  - Exactly one cycle. Done=1, Stall=0, Busy=0.
  - Read: DataOut = latched word.
  - Write: the storage word is written on the edge that enters DONE, and DataOut keeps its prior value.
  - Request inputs are ignored in this cycle, because the same instruction still drives Rd/Wr; next state is IDLE.
- Timing: a request accepted at edge E0 gives Done high in the cycle after edge E0+LATENCY-1. With LATENCY=4, Stall is high for 4 cycles (the request cycle plus 3 BUSY cycles), then Done is high for 1 cycle.
- Back-to-back: a new legal request is accepted no earlier than the first IDLE cycle after DONE.
- Read-after-write to the same address on consecutive accesses returns the new data.
- err:
  - Asserted only in IDLE, combinationally = illegal.
  - No state change, no storage update, Stall=0, Done=0.
  - Requester latches err externally.
  - err is 0 in BUSY and DONE.
- Reset mid-access: the in-flight write is discarded, state returns to IDLE, and Done is never pulsed for the aborted access.
- Rd=Wr=0 in IDLE: no activity, all outputs hold. DataOut is never cleared except by reset.

Test Plan:
- Reset, then Rd at Addr=0x0010 with LATENCY=4 -> Stall=1 for 4 cycles, Done=1 on 5th cycle, DataOut=0x0000, Busy=1 for 3 cycles.
- Wr Addr=0x0020 DataIn=0xBEEF, then after Done, Rd Addr=0x0020 -> second access Done with DataOut=0xBEEF; Stall drops in each Done cycle.
- Illegal requests:
  - Rd Addr=0x0021 (odd) -> err=1 same cycle, Stall=0, no Done, storage unchanged.
  - Rd&Wr together -> err=1.
  - Addr=0x0200 with MEM_WORDS=256 -> err=1.
- Hold Rd high through DONE and continue into the next cycle -> exactly one Done pulse per acceptance; the re-accept happens only in the following IDLE cycle, so the next Done arrives 5 cycles later.
- Wr Addr=0x0004 DataIn=0x1234, drop rst in 2nd BUSY cycle, release, then Rd 0x0004 -> Done never seen for the write; read returns 0x0000.
- LATENCY=1 build: Rd 0x0002 after Wr 0x0002 DataIn=0x00FF -> Stall high only in the request cycle, Done next cycle, DataOut=0x00FF.
